// File: rtl/color_bbox.sv
// Camera FIFO consumer: tags RGB565 pixels with (x, y) and a color-window match,
// and publishes per-frame bounding box and match count at end of frame.
module color_bbox #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned X_W      = 10,
    parameter int unsigned Y_W      = 9,
    parameter int unsigned CNT_W    = 19
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_frame_start,
    output logic             o_obuf_rd,
    input  logic [15:0]      i_obuf_data,
    input  logic             i_obuf_empty,
    input  logic [4:0]       i_r_min,
    input  logic [4:0]       i_r_max,
    input  logic [5:0]       i_g_min,
    input  logic [5:0]       i_g_max,
    input  logic [4:0]       i_b_min,
    input  logic [4:0]       i_b_max,
    output logic             o_pix_valid,
    output logic [15:0]      o_pix_data,
    output logic [X_W-1:0]   o_pix_x,
    output logic [Y_W-1:0]   o_pix_y,
    output logic             o_pix_match,
    output logic             o_bbox_valid,
    output logic             o_bbox_found,
    output logic [X_W-1:0]   o_xmin,
    output logic [X_W-1:0]   o_xmax,
    output logic [Y_W-1:0]   o_ymin,
    output logic [Y_W-1:0]   o_ymax,
    output logic [CNT_W-1:0] o_count,
    output logic             o_frame_abort
);

    localparam logic [CNT_W-1:0] FRAME_PIX = CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(V_ACTIVE - 1);

    typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] rd_cnt_q;
    logic [CNT_W-1:0] count_q;
    logic [X_W-1:0]   x_q, xmin_q, xmax_q;
    logic [Y_W-1:0]   y_q, ymin_q, ymax_q;
    logic             data_vld_q;
    logic             in_match;
    logic             last_pix;
    logic [4:0]       r;
    logic [5:0]       g;
    logic [4:0]       b;

    always_comb begin
        r = i_obuf_data[15:11];
        g = i_obuf_data[10:5];
        b = i_obuf_data[4:0];
        // Gated by reset so the read strobe is also quiet while reset is held.
        o_obuf_rd = i_rstn && !i_obuf_empty &&
                    (state_q == StIdle || (state_q == StActive && rd_cnt_q < FRAME_PIX));
        in_match  = (r >= i_r_min) && (r <= i_r_max) &&
                    (g >= i_g_min) && (g <= i_g_max) &&
                    (b >= i_b_min) && (b <= i_b_max);
        last_pix  = o_pix_valid && (o_pix_x == X_LAST) && (o_pix_y == Y_LAST);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q       <= StIdle;
            rd_cnt_q      <= '0;
            count_q       <= '0;
            x_q           <= '0;
            y_q           <= '0;
            xmin_q        <= '1;
            xmax_q        <= '0;
            ymin_q        <= '1;
            ymax_q        <= '0;
            data_vld_q    <= 1'b0;
            o_pix_valid   <= 1'b0;
            o_pix_data    <= '0;
            o_pix_x       <= '0;
            o_pix_y       <= '0;
            o_pix_match   <= 1'b0;
            o_bbox_valid  <= 1'b0;
            o_bbox_found  <= 1'b0;
            o_xmin        <= '0;
            o_xmax        <= '0;
            o_ymin        <= '0;
            o_ymax        <= '0;
            o_count       <= '0;
            o_frame_abort <= 1'b0;
        end else begin
            o_bbox_valid  <= 1'b0;
            o_frame_abort <= 1'b0;
            // A read in the frame_start cycle belongs to the old frame; drop it.
            data_vld_q    <= o_obuf_rd && (state_q == StActive) && !i_frame_start;
            o_pix_valid   <= data_vld_q && !i_frame_start;
            if (data_vld_q) begin
                o_pix_data  <= i_obuf_data;
                o_pix_match <= in_match;
                o_pix_x     <= x_q;
                o_pix_y     <= y_q;
            end

            if (i_frame_start) begin
                state_q  <= StActive;
                rd_cnt_q <= '0;
                x_q      <= '0;
                y_q      <= '0;
                count_q  <= '0;
                xmin_q   <= '1;
                xmax_q   <= '0;
                ymin_q   <= '1;
                ymax_q   <= '0;
                if (state_q == StActive) o_frame_abort <= 1'b1;
            end else begin
                if (o_obuf_rd && state_q == StActive) rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                if (data_vld_q) begin
                    if (x_q == X_LAST) begin
                        x_q <= '0;
                        y_q <= y_q + Y_W'(1);
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
                if (o_pix_valid && o_pix_match) begin
                    count_q <= count_q + CNT_W'(1);
                    if (o_pix_x < xmin_q) xmin_q <= o_pix_x;
                    if (o_pix_x > xmax_q) xmax_q <= o_pix_x;
                    if (o_pix_y < ymin_q) ymin_q <= o_pix_y;
                    if (o_pix_y > ymax_q) ymax_q <= o_pix_y;
                end
                unique case (state_q)
                    StIdle:   state_q <= StIdle;
                    StActive: if (last_pix) state_q <= StDone;
                    StDone:   state_q <= StIdle;
                    default:  state_q <= StIdle;
                endcase
            end

            // Publish uses the pre-reset accumulators even if frame_start arrives here.
            if (state_q == StDone) begin
                o_bbox_valid <= 1'b1;
                o_bbox_found <= (count_q != '0);
                o_count      <= count_q;
                o_xmin       <= (count_q != '0) ? xmin_q : '0;
                o_xmax       <= (count_q != '0) ? xmax_q : '0;
                o_ymin       <= (count_q != '0) ? ymin_q : '0;
                o_ymax       <= (count_q != '0) ? ymax_q : '0;
            end
        end
    end

endmodule

// File: tb/tb_color_bbox.sv
// Directed bench for color_bbox: small frame, behavioral FIFO, vector table plus
// hand-written pre-frame drain, abort and mid-frame reset sequences.
module tb_color_bbox;

    localparam int H = 8;
    localparam int V = 4;
    localparam int N = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        obuf_rd;
    logic [15:0] obuf_data = '0;
    logic        obuf_empty;
    logic [4:0]  r_min = '0, r_max = '0, b_min = '0, b_max = '0;
    logic [5:0]  g_min = '0, g_max = '0;
    logic        pix_valid, pix_match, bbox_valid, bbox_found, frame_abort;
    logic [15:0] pix_data;
    logic [2:0]  pix_x, xmin, xmax;
    logic [1:0]  pix_y, ymin, ymax;
    logic [5:0]  count;

    color_bbox #(.H_ACTIVE(H), .V_ACTIVE(V), .X_W(3), .Y_W(2), .CNT_W(6)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_frame_start(frame_start),
        .o_obuf_rd(obuf_rd), .i_obuf_data(obuf_data), .i_obuf_empty(obuf_empty),
        .i_r_min(r_min), .i_r_max(r_max), .i_g_min(g_min), .i_g_max(g_max),
        .i_b_min(b_min), .i_b_max(b_max),
        .o_pix_valid(pix_valid), .o_pix_data(pix_data), .o_pix_x(pix_x),
        .o_pix_y(pix_y), .o_pix_match(pix_match),
        .o_bbox_valid(bbox_valid), .o_bbox_found(bbox_found),
        .o_xmin(xmin), .o_xmax(xmax), .o_ymin(ymin), .o_ymax(ymax),
        .o_count(count), .o_frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    // Behavioral FIFO: one-cycle read latency, optional random empty gaps.
    logic [15:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          rd_empty_err = 0;
    logic        gap = 1'b0;
    logic        gap_en = 1'b0;

    assign obuf_empty = (wr_ptr == rd_ptr) || gap;

    always @(posedge clk) begin
        if (obuf_rd) begin
            if (obuf_empty) rd_empty_err <= rd_empty_err + 1;
            else begin
                obuf_data <= mem[rd_ptr % 1024];
                rd_ptr    <= rd_ptr + 1;
            end
        end
        gap <= gap_en && ($urandom_range(0, 1) == 1);
    end

    // Output monitor
    int          cyc = 0, pix_n = 0, bbox_n = 0, abort_n = 0;
    int          last_pix_cyc = 0, bbox_cyc = 0;
    logic [15:0] cap_data [0:511];
    logic [2:0]  cap_x [0:511];
    logic [1:0]  cap_y [0:511];
    logic        cap_m [0:511];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (pix_valid && pix_n < 512) begin
            cap_data[pix_n] <= pix_data;
            cap_x[pix_n]    <= pix_x;
            cap_y[pix_n]    <= pix_y;
            cap_m[pix_n]    <= pix_match;
            pix_n           <= pix_n + 1;
            last_pix_cyc    <= cyc;
        end
        if (bbox_valid) begin
            bbox_n   <= bbox_n + 1;
            bbox_cyc <= cyc;
        end
        if (frame_abort) abort_n <= abort_n + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [4:0] rmin, rmax;
        logic [5:0] gmin, gmax;
        logic [4:0] bmin, bmax;
        int         pat;
        logic       gaps;
        int         exmin, exmax, eymin, eymax, ecount, efound;
    } vec_t;

    function automatic logic [15:0] pix_val(input int pat, input int k);
        logic [15:0] v;
        case (pat)
            0:       v = 16'(k) * 16'h0841;
            1:       v = (k == 10 || k == 29) ? 16'hF800 : 16'h0000;
            default: v = 16'hF800;
        endcase
        return v;
    endfunction

    function automatic logic model_match(input vec_t v, input logic [15:0] d);
        return d[15:11] >= v.rmin && d[15:11] <= v.rmax &&
               d[10:5]  >= v.gmin && d[10:5]  <= v.gmax &&
               d[4:0]   >= v.bmin && d[4:0]   <= v.bmax;
    endfunction

    function automatic logic [63:0] all_outs();
        return {21'd0, obuf_rd, pix_valid, pix_data, pix_x, pix_y, pix_match, bbox_valid,
                bbox_found, xmin, xmax, ymin, ymax, count, frame_abort};
    endfunction

    task automatic push(input logic [15:0] d);
        mem[wr_ptr % 1024] = d;
        wr_ptr++;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    task automatic set_window(input vec_t v);
        r_min = v.rmin; r_max = v.rmax;
        g_min = v.gmin; g_max = v.gmax;
        b_min = v.bmin; b_max = v.bmax;
        gap_en = v.gaps;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int pb, bb, ab, pop0, t, got;
        set_window(v);
        pb = pix_n; bb = bbox_n; ab = abort_n; pop0 = rd_ptr;
        pulse_start();
        for (int k = 0; k < N; k++) push(pix_val(v.pat, k));
        t = 0;
        while (bbox_n == bb && t < 400) begin @(posedge clk); t++; end
        repeat (5) @(posedge clk);
        @(negedge clk);
        got = pix_n - pb;
        chk($sformatf("v%0d pix_count", id), 64'(got), 64'(N));
        if (got > N) got = N;
        for (int k = 0; k < got; k++) begin
            chk($sformatf("v%0d px%0d data", id, k), 64'(cap_data[pb + k]), 64'(pix_val(v.pat, k)));
            chk($sformatf("v%0d px%0d x", id, k), 64'(cap_x[pb + k]), 64'(k % H));
            chk($sformatf("v%0d px%0d y", id, k), 64'(cap_y[pb + k]), 64'(k / H));
            chk($sformatf("v%0d px%0d match", id, k), 64'(cap_m[pb + k]),
                64'(model_match(v, pix_val(v.pat, k))));
        end
        chk($sformatf("v%0d bbox_pulses", id), 64'(bbox_n - bb), 64'd1);
        chk($sformatf("v%0d bbox_latency", id), 64'(bbox_cyc - last_pix_cyc), 64'd2);
        chk($sformatf("v%0d aborts", id), 64'(abort_n - ab), 64'd0);
        chk($sformatf("v%0d reads", id), 64'(rd_ptr - pop0), 64'(N));
        chk($sformatf("v%0d xmin", id), 64'(xmin), 64'(v.exmin));
        chk($sformatf("v%0d xmax", id), 64'(xmax), 64'(v.exmax));
        chk($sformatf("v%0d ymin", id), 64'(ymin), 64'(v.eymin));
        chk($sformatf("v%0d ymax", id), 64'(ymax), 64'(v.eymax));
        chk($sformatf("v%0d count", id), 64'(count), 64'(v.ecount));
        chk($sformatf("v%0d found", id), 64'(bbox_found), 64'(v.efound));
        gap_en = 1'b0;
    endtask

    vec_t vecs [5];

    initial begin
        int pb, bb, ab, pop0, t;
        vecs[0] = '{5'd0,  5'd31, 6'd0, 6'd63, 5'd0, 5'd31, 0, 1'b0, 0, 7, 0, 3, 32, 1};
        vecs[1] = '{5'd31, 5'd31, 6'd0, 6'd0,  5'd0, 5'd0,  1, 1'b0, 2, 5, 1, 3, 2,  1};
        vecs[2] = '{5'd20, 5'd10, 6'd0, 6'd63, 5'd0, 5'd31, 0, 1'b0, 0, 0, 0, 0, 0,  0};
        vecs[3] = '{5'd0,  5'd31, 6'd0, 6'd63, 5'd0, 5'd31, 0, 1'b1, 0, 7, 0, 3, 32, 1};
        vecs[4] = '{5'd10, 5'd12, 6'd0, 6'd63, 5'd0, 5'd31, 0, 1'b1, 2, 4, 1, 1, 3,  1};

        // Reset state
        #23;
        chk("reset_outputs", all_outs(), 64'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("idle_outputs", all_outs(), 64'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Pre-frame pixels are drained silently; abort after 10 pixels restarts.
        set_window(vecs[1]);
        pb = pix_n; pop0 = rd_ptr; bb = bbox_n; ab = abort_n;
        for (int k = 0; k < 5; k++) push(16'hF800);
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("predrain_reads", 64'(rd_ptr - pop0), 64'd5);
        chk("predrain_no_pix", 64'(pix_n - pb), 64'd0);
        pulse_start();
        for (int k = 0; k < 10; k++) push(16'hF800);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("partial_pix", 64'(pix_n - pb), 64'd10);
        pb = pix_n;
        pulse_start();
        for (int k = 0; k < N; k++) push(pix_val(1, k));
        t = 0;
        while (bbox_n == bb && t < 400) begin @(posedge clk); t++; end
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("abort_pulses", 64'(abort_n - ab), 64'd1);
        chk("abort_bbox_pulses", 64'(bbox_n - bb), 64'd1);
        chk("abort_pix", 64'(pix_n - pb), 64'(N));
        chk("abort_first_xy", 64'({cap_x[pb], cap_y[pb]}), 64'd0);
        chk("abort_bbox", 64'({xmin, xmax, ymin, ymax}), 64'({3'd2, 3'd5, 2'd1, 2'd3}));
        chk("abort_count", 64'(count), 64'd2);

        // Asynchronous reset in the middle of a frame.
        set_window(vecs[0]);
        pb = pix_n; bb = bbox_n;
        pulse_start();
        for (int k = 0; k < N; k++) push(pix_val(0, k));
        t = 0;
        while (pix_n - pb < 20 && t < 300) begin @(negedge clk); t++; end
        #2 rst_n = 1'b0;
        #1 chk("midreset_outputs", all_outs(), 64'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        pb = pix_n;
        repeat (30) @(posedge clk);
        @(negedge clk);
        chk("midreset_no_bbox", 64'(bbox_n - bb), 64'd0);
        chk("midreset_no_pix", 64'(pix_n - pb), 64'd0);
        run_vec(vecs[1], 5);

        chk("rd_while_empty", 64'(rd_empty_err), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/color_bbox.md
# color_bbox

Downstream consumer of the camera output buffer FIFO, running in the FIFO read-clock domain. Pops RGB565 pixels, tags each with its (x, y) position and whether it falls inside a programmable per-channel color window, and forwards them as a pixel stream. Per frame, it accumulates the bounding box and the count of matching pixels, and publishes them at end of frame for the color-detect tracker.

## Interface
- H_ACTIVE, 640, pixels per line
- V_ACTIVE, 480, lines per frame
- X_W, 10, x coordinate width
- Y_W, 9, y coordinate width
- CNT_W, 19, match-count width (must hold H_ACTIVE*V_ACTIVE)

- i_clk  in  1  FIFO read clock (same net as obuf read clock)
- i_rstn  in  1  reset; asynchronous, active-low
- i_frame_start  in  1  one-cycle pulse, start of frame, already synchronized to i_clk
- o_obuf_rd  out  1  FIFO read enable
- i_obuf_data  in  16  FIFO read data, valid the cycle after an accepted read
- i_obuf_empty  in  1  FIFO empty flag
- i_r_min, i_r_max  in  5  red window, inclusive
- i_g_min, i_g_max  in  6  green window, inclusive
- i_b_min, i_b_max  in  5  blue window, inclusive
- o_pix_valid  out  1  pixel stream strobe; no backpressure
- o_pix_data  out  16  RGB565 pixel
- o_pix_x  out  X_W  pixel column
- o_pix_y  out  Y_W  pixel row
- o_pix_match  out  1  pixel inside the color window
- o_bbox_valid  out  1  one-cycle pulse, frame results updated
- o_bbox_found  out  1  o_count != 0
- o_xmin, o_xmax  out  X_W  bounding box columns
- o_ymin, o_ymax  out  Y_W  bounding box rows
- o_count  out  CNT_W  matching pixels in the frame
- o_frame_abort  out  1  one-cycle pulse, frame restarted before completion

## Operation
- States:
  - IDLE: drain and discard FIFO data.
  - ACTIVE: capture the frame.
  - DONE: one cycle; publish results.
- Transitions:
  - Any state goes to ACTIVE on i_frame_start.
  - ACTIVE goes to DONE after the statistics update for pixel H_ACTIVE*V_ACTIVE-1.
  - DONE goes to IDLE unless i_frame_start is asserted.
- Read enable: o_obuf_rd = !i_obuf_empty && (IDLE || (ACTIVE && rd_cnt < H_ACTIVE*V_ACTIVE)). rd_cnt counts reads accepted in ACTIVE; reads never exceed one frame.
- Data qualification: data popped in IDLE or DONE is discarded. This includes a read in the same cycle i_frame_start is seen; that read belongs to the old frame.
- Position counters: x increments per pixel and wraps at H_ACTIVE-1 to 0, then y increments. x, y and rd_cnt clear on i_frame_start.
- Match rule: R=data[15:11], G=[10:5], B=[4:0]. Match iff min<=c<=max for all three channels, unsigned. A channel with min>max never matches.
- Accumulators on i_frame_start:
  - xmin and ymin go to all-ones; xmax and ymax go to 0; count goes to 0.
  - On each matching pixel: xmin=min(xmin,x), xmax=max, ymin/ymax likewise, count+1.
- DONE behavior:
  - Accumulators copy to the o_bbox*/o_count registers; o_bbox_valid=1.
  - When count=0, publish xmin=xmax=ymin=ymax=0 and o_bbox_found=0.
  - Outputs hold until the next DONE.
- Abort: i_frame_start in ACTIVE pulses o_frame_abort and discards partial statistics, including data in flight from the previous cycle's read. Published results are unchanged, and the frame restarts.
- i_frame_start in DONE: results still publish that cycle, and the next state is ACTIVE.
- Upstream guarantee: i_frame_start precedes the first pixel of its frame appearing non-empty in the FIFO.

## Timing
- Reset values: all outputs 0, state IDLE, accumulators at the i_frame_start values.
- Latency:
  - Read at cycle N: i_obuf_data is valid at N+1.
  - o_pix_valid/data/x/y/match are registered and valid at N+2.
  - Accumulators reflect that pixel at N+3.
- o_bbox_valid asserts one cycle after the accumulator update of the last pixel, i.e. 2 cycles after the last o_pix_valid.
- Sustained throughput: 1 pixel/cycle while the FIFO is non-empty. Empty gaps insert bubbles, and o_pix_valid stays low in those cycles.
- Reset asserted mid-frame: all outputs go to 0 immediately, with no bbox pulse.

## Test plan
All scenarios use H_ACTIVE=8, V_ACTIVE=4, X_W=3, Y_W=2, CNT_W=6, and a behavioral FIFO model.

1. Window fully open (0..31/0..63/0..31), 32 pixels, FIFO never empty -> 32 o_pix_valid cycles with x 0..7 and y 0..3. o_bbox_valid fires once: xmin=0, xmax=7, ymin=0, ymax=3, count=32, found=1.
2. Window R=31..31, G=0..0, B=0..0. Pixels 16'hF800 only at (2,1) and (5,3), all others 16'h0000 -> xmin=2, xmax=5, ymin=1, ymax=3, count=2.
3. No matching pixel (r_min=20 > r_max=10) -> count=0, found=0, bbox=0/0/0/0. o_pix_match is never high.
4. Random empty gaps (50% duty) -> same o_pix stream values as scenario 1. Exactly 32 reads issued in ACTIVE, and o_obuf_rd is never asserted while empty.
5. Pixels present before the first i_frame_start, and i_frame_start reissued after 10 pixels -> pre-frame pixels drained with no o_pix_valid. o_frame_abort pulses once, and results reflect only the second 32-pixel frame.
6. i_rstn deasserted asynchronously at pixel 20 -> outputs 0 within the reset; no o_bbox_valid. The next full frame after reset reports correct results.
